// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the frame loader (write side of the ping-pong
// display buffers).
//   - loader_state_t : loader FSM states
//   - DEFAULT_ADDR_W / DEFAULT_DATA_W : default buffer address / pixel widths
//   - RGB field slice positions inside a 24-bit pixel {R, G, B}
// No ports (package).
// ---------------------------------------------------------------------------
package display_pkg;

    localparam int DEFAULT_ADDR_W = 20;
    localparam int DEFAULT_DATA_W = 24;

    // Pixel layout is {R[23:16], G[15:8], B[7:0]}
    localparam int RED_HI   = 23;
    localparam int RED_LO   = 16;
    localparam int GREEN_HI = 15;
    localparam int GREEN_LO = 8;
    localparam int BLUE_HI  = 7;
    localparam int BLUE_LO  = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL0 = 3'd1,
        FULL0 = 3'd2,
        FILL1 = 3'd3,
        FULL1 = 3'd4
    } loader_state_t;

endpackage

// File: rtl/frame_loader_if.sv
// ---------------------------------------------------------------------------
// frame_loader_if
// Pixel stream handshake between a pixel source and the frame loader.
//   PxValid : source has a pixel
//   PxSof   : pixel is the first of a frame
//   PxData  : pixel {R, G, B}
//   PxReady : loader accepts the pixel this cycle
// Modports: master (pixel source), slave (frame loader).
// ---------------------------------------------------------------------------
interface frame_loader_if
    import display_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              PxValid;
    logic              PxSof;
    logic [DATA_W-1:0] PxData;
    logic              PxReady;

    modport master (
        output PxValid,
        output PxSof,
        output PxData,
        input  PxReady
    );

    modport slave (
        input  PxValid,
        input  PxSof,
        input  PxData,
        output PxReady
    );
endinterface

// File: rtl/frame_pos_counter.sv
// ---------------------------------------------------------------------------
// frame_pos_counter
// Tracks the write position inside the frame being loaded: pixel-in-line
// (px), line-in-frame (line) and the linear buffer address (addr).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   inc_i              : a pixel was accepted this cycle
//   clr_i              : frame finished, return to position 0 (wins over inc)
//   realign_i          : accepted pixel is being forced to position 0
//   aip_i, ail_i       : active pixels per line / lines per frame (0 = 1024)
//   addr_o             : address for the pixel accepted this cycle
//   at_origin_o        : current position is (px=0, line=0)
//   last_px_o          : px is the last pixel of the line
//   last_line_o        : line is the last line of the frame
// ---------------------------------------------------------------------------
module frame_pos_counter
    import display_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_i,
    input  logic              clr_i,
    input  logic              realign_i,
    input  logic [9:0]        aip_i,
    input  logic [9:0]        ail_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              at_origin_o,
    output logic              last_px_o,
    output logic              last_line_o
);

    logic [9:0]        px_q, px_d;
    logic [9:0]        line_q, line_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // The compares are 10-bit and wrap, so a count of 0 behaves as 1024.
    assign last_px_o   = (px_q == aip_i - 10'd1);
    assign last_line_o = (line_q == ail_i - 10'd1);
    assign at_origin_o = (px_q == 10'd0) && (line_q == 10'd0);
    assign addr_o      = addr_q;

    // Next position. A realigned pixel is treated as if it had landed at
    // position 0, so the following pixel continues from position 1 (which
    // is the start of line 1 when lines are a single pixel long).
    always_comb begin
        px_d   = px_q;
        line_d = line_q;
        addr_d = addr_q;
        if (clr_i) begin
            px_d   = 10'd0;
            line_d = 10'd0;
            addr_d = '0;
        end else if (inc_i) begin
            if (realign_i) begin
                if (aip_i == 10'd1) begin
                    px_d   = 10'd0;
                    line_d = 10'd1;
                end else begin
                    px_d   = 10'd1;
                    line_d = 10'd0;
                end
                addr_d = ADDR_W'(1);
            end else begin
                if (last_px_o) begin
                    px_d   = 10'd0;
                    line_d = line_q + 10'd1;
                end else begin
                    px_d   = px_q + 10'd1;
                end
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            px_q   <= 10'd0;
            line_q <= 10'd0;
            addr_q <= '0;
        end else begin
            px_q   <= px_d;
            line_q <= line_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/frame_loader.sv
// ---------------------------------------------------------------------------
// frame_loader
// Accepts a pixel stream and writes whole frames alternately into ping-pong
// buffers 0 and 1, as permitted by the display controller grants WE0/WE1.
// Reports buffer-full status and raises CSDisplay once buffer 0 first holds
// a complete frame.
// Optional feature macro: FRAME_LOADER_SOF_CHECK_EN
//   defined   : PxSof is checked against the write position; misalignment
//               sets the sticky SyncErr and an early SOF realigns to addr 0
//   undefined : PxSof ignored, SyncErr tied to 0
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   AIPIn, AILIn        : active pixels per line / lines per frame (0 = 1024),
//                         latched when a fill starts
//   pxIf (slave)        : PxValid/PxSof/PxData in, PxReady out
//   WE0, WE1            : write grants for buffer 0 / 1
//   WrEn0, WrEn1        : buffer write strobes (never both high)
//   WrAddr, WrData      : write address / data, valid with a strobe, else 0
//   Buf0Full, Buf1Full  : buffer holds a complete frame
//   FrameDone           : one-cycle pulse after a frame completes
//   CSDisplay           : first frame resident, display may start
//   SyncErr             : sticky SOF misalignment flag
// ---------------------------------------------------------------------------
module frame_loader
    import display_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        AIPIn,
    input  logic [9:0]        AILIn,
    frame_loader_if.slave     pxIf,
    input  logic              WE0,
    input  logic              WE1,
    output logic              WrEn0,
    output logic              WrEn1,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [DATA_W-1:0] WrData,
    output logic              Buf0Full,
    output logic              Buf1Full,
    output logic              FrameDone,
    output logic              CSDisplay,
    output logic              SyncErr
);

    loader_state_t state_q, state_d;
    logic [9:0]    aip_q, ail_q;
    logic          buf0Full_q, buf0Full_d;
    logic          buf1Full_q, buf1Full_d;
    logic          frameDone_q;
    logic          csDisplay_q, csDisplay_d;
    logic          syncErr_q, syncErr_d;

    logic              fillActive;
    logic              fillBuf;
    logic              pxReady;
    logic              accept;
    logic              realign;
    logic              sofErr;
    logic              endPos;
    logic              frameEnd;
    logic              enterFill;
    logic [ADDR_W-1:0] addr;
    logic              atOrigin;
    logic              lastPx;
    logic              lastLine;

    frame_pos_counter #(
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clk         (clk),
        .reset       (reset),
        .inc_i       (accept),
        .clr_i       (frameEnd),
        .realign_i   (realign),
        .aip_i       (aip_q),
        .ail_i       (ail_q),
        .addr_o      (addr),
        .at_origin_o (atOrigin),
        .last_px_o   (lastPx),
        .last_line_o (lastLine)
    );

    // Decode which buffer (if any) is currently being filled.
    always_comb begin
        fillActive = 1'b0;
        fillBuf    = 1'b0;
        case (state_q)
            FILL0:   fillActive = 1'b1;
            FILL1: begin
                fillActive = 1'b1;
                fillBuf    = 1'b1;
            end
            default: ;
        endcase
    end

    // Losing the grant mid-fill simply stalls the handshake; the position
    // counter only moves on accepts, so nothing else needs to hold.
    assign pxReady     = fillActive & (fillBuf ? WE1 : WE0);
    assign pxIf.PxReady = pxReady;
    assign accept      = pxIf.PxValid & pxReady;

`ifdef FRAME_LOADER_SOF_CHECK_EN
    // An early SOF restarts the frame at address 0; a missing SOF at the
    // frame origin is only flagged. The realigned pixel sits at position 0,
    // so it closes the frame only when the frame is a single pixel.
    assign realign = accept & pxIf.PxSof & ~atOrigin;
    assign sofErr  = realign | (accept & ~pxIf.PxSof & atOrigin);
    assign endPos  = realign ? ((aip_q == 10'd1) && (ail_q == 10'd1))
                             : (lastPx & lastLine);
`else
    logic unusedSof;
    assign unusedSof = pxIf.PxSof ^ atOrigin;
    assign realign   = 1'b0;
    assign sofErr    = 1'b0;
    assign endPos    = lastPx & lastLine;
`endif

    assign frameEnd = accept & endPos;

    // Write port is driven straight from the accept so the pixel lands in
    // the same cycle; address and data read as 0 when nothing is written.
    assign WrEn0  = accept & ~fillBuf;
    assign WrEn1  = accept & fillBuf;
    assign WrAddr = accept ? (realign ? '0 : addr) : '0;
    assign WrData = accept ? pxIf.PxData : '0;

    // FSM next state. WE0 is the only way out of IDLE, so it naturally
    // wins when both grants are high after reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (WE0)      state_d = FILL0;
            FILL0:   if (frameEnd) state_d = FULL0;
            FULL0:   if (WE1)      state_d = FILL1;
            FILL1:   if (frameEnd) state_d = FULL1;
            FULL1:   if (WE0)      state_d = FILL0;
            default:               state_d = IDLE;
        endcase
    end

    assign enterFill = ((state_d == FILL0) && (state_q != FILL0)) ||
                       ((state_d == FILL1) && (state_q != FILL1));

    // Status flags. A buffer's full flag drops when a new fill of that
    // buffer begins and rises the cycle after its final pixel.
    always_comb begin
        buf0Full_d  = buf0Full_q;
        buf1Full_d  = buf1Full_q;
        csDisplay_d = csDisplay_q;
        syncErr_d   = syncErr_q | sofErr;
        if ((state_d == FILL0) && (state_q != FILL0)) buf0Full_d = 1'b0;
        if ((state_d == FILL1) && (state_q != FILL1)) buf1Full_d = 1'b0;
        if (frameEnd) begin
            if (fillBuf) begin
                buf1Full_d = 1'b1;
            end else begin
                buf0Full_d  = 1'b1;
                csDisplay_d = 1'b1;
            end
        end
    end

    // State and status registers; frame geometry is captured on fill entry
    // so a change of AIPIn/AILIn never disturbs a frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            aip_q       <= 10'd0;
            ail_q       <= 10'd0;
            buf0Full_q  <= 1'b0;
            buf1Full_q  <= 1'b0;
            frameDone_q <= 1'b0;
            csDisplay_q <= 1'b0;
            syncErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf0Full_q  <= buf0Full_d;
            buf1Full_q  <= buf1Full_d;
            frameDone_q <= frameEnd;
            csDisplay_q <= csDisplay_d;
            syncErr_q   <= syncErr_d;
            if (enterFill) begin
                aip_q <= AIPIn;
                ail_q <= AILIn;
            end
        end
    end

    assign Buf0Full  = buf0Full_q;
    assign Buf1Full  = buf1Full_q;
    assign FrameDone = frameDone_q;
    assign CSDisplay = csDisplay_q;
    assign SyncErr   = syncErr_q;

endmodule

// File: tb/tb_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_frame_loader
// Scoreboard bench for frame_loader: every pixel presented to the loader
// pushes its expected buffer/address/data, and the write-port monitor pops
// and compares on each write strobe.
// ---------------------------------------------------------------------------
module tb_frame_loader;

    logic        clk;
    logic        reset;
    logic [9:0]  AIPIn;
    logic [9:0]  AILIn;
    logic        WE0;
    logic        WE1;
    logic        WrEn0;
    logic        WrEn1;
    logic [19:0] WrAddr;
    logic [23:0] WrData;
    logic        Buf0Full;
    logic        Buf1Full;
    logic        FrameDone;
    logic        CSDisplay;
    logic        SyncErr;

    frame_loader_if #(.DATA_W(24)) pxIf ();

    frame_loader #(
        .ADDR_W (20),
        .DATA_W (24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .AIPIn     (AIPIn),
        .AILIn     (AILIn),
        .pxIf      (pxIf),
        .WE0       (WE0),
        .WE1       (WE1),
        .WrEn0     (WrEn0),
        .WrEn1     (WrEn1),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .Buf0Full  (Buf0Full),
        .Buf1Full  (Buf1Full),
        .FrameDone (FrameDone),
        .CSDisplay (CSDisplay),
        .SyncErr   (SyncErr)
    );

`ifdef FRAME_LOADER_SOF_CHECK_EN
    localparam bit SOF_EN = 1'b1;
`else
    localparam bit SOF_EN = 1'b0;
`endif

    typedef struct packed {
        logic        bufSel;
        logic [19:0] addr;
        logic [23:0] data;
    } wrExp_t;

    wrExp_t expQ[$];
    int     totalChecks = 0;
    int     badChecks   = 0;

    logic [51:0] outVec;
    assign outVec = {pxIf.PxReady, WrEn0, WrEn1, WrAddr, WrData,
                     Buf0Full, Buf1Full, FrameDone, CSDisplay, SyncErr};

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the loader never completes a handshake loop.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (WrEn0 || WrEn1) begin
            checkOutput("wr_exclusive", {WrEn1, WrEn0} == 2'b11, 1'b0);
            checkOutput("sb_has_entry", expQ.size() != 0, 1'b1);
            if (expQ.size() != 0) begin
                wrExp_t e;
                e = expQ.pop_front();
                checkOutput("wr_buf", {WrEn1, WrEn0},
                            e.bufSel ? 2'b10 : 2'b01);
                checkOutput("wr_addr", WrAddr, e.addr);
                checkOutput("wr_data", WrData, e.data);
            end
        end
    end

    // Present one pixel and wait (bounded) until the loader takes it.
    // Returns 1 time unit after the accepting clock edge.
    task automatic applyStimulus(input logic b, input logic [19:0] a,
                                 input logic [23:0] d, input logic sof);
        bit gotReady;
        gotReady      = 1'b0;
        pxIf.PxValid  = 1'b1;
        pxIf.PxData   = d;
        pxIf.PxSof    = sof;
        expQ.push_back('{bufSel: b, addr: a, data: d});
        for (int i = 0; i < 64 && !gotReady; i++) begin
            @(negedge clk);
            if (pxIf.PxReady) begin
                gotReady = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        checkOutput("accept_wait", gotReady, 1'b1);
    endtask

    task automatic runFrame(input logic b, input int n, input logic [7:0] tag);
        for (int i = 0; i < n; i++)
            applyStimulus(b, 20'(i), {tag, 8'(i), 8'h5A}, i == 0);
    endtask

    task automatic checkFrameDone(input logic b, input string tag);
        pxIf.PxValid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_full"}, b ? Buf1Full : Buf0Full, 1'b1);
        checkOutput({tag, "_done"}, FrameDone, 1'b1);
        @(negedge clk);
        checkOutput({tag, "_done_fall"}, FrameDone, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        AIPIn        = 10'd4;
        AILIn        = 10'd2;
        WE0          = 1'b1;
        WE1          = 1'b0;
        pxIf.PxValid = 1'b1;
        pxIf.PxSof   = 1'b0;
        pxIf.PxData  = 24'hFFFFFF;

        // Reset with live inputs: all outputs must read 0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outs", outVec, 52'd0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        pxIf.PxValid = 1'b0;

        // Frame A into buffer 0, 4x2, back to back.
        runFrame(1'b0, 8, 8'hA0);
        pxIf.PxValid = 1'b0;
        @(negedge clk);
        checkOutput("a_cs", CSDisplay, 1'b1);
        checkOutput("a_full", Buf0Full, 1'b1);
        checkOutput("a_done", FrameDone, 1'b1);
        @(negedge clk);
        checkOutput("a_done_fall", FrameDone, 1'b0);
        checkOutput("a_hold_rdy", pxIf.PxReady, 1'b0);
        @(posedge clk);
        #1;

        // Frame B into buffer 1.
        WE0 = 1'b0;
        WE1 = 1'b1;
        runFrame(1'b1, 8, 8'hB0);
        checkFrameDone(1'b1, "b");
        checkOutput("b_buf0_kept", Buf0Full, 1'b1);
        checkOutput("b_cs_hold", CSDisplay, 1'b1);

        // Regranting buffer 0 clears its full flag.
        WE1 = 1'b0;
        WE0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("c_buf0_clr", Buf0Full, 1'b0);
        checkOutput("c_buf1_kept", Buf1Full, 1'b1);
        checkOutput("c_ready", pxIf.PxReady, 1'b1);
        @(posedge clk);
        #1;

        // Frame C: grant dropped after pixel 3, then valid toggling.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 20'(i), {8'hC0, 8'(i), 8'h5A}, i == 0);
        WE0          = 1'b0;
        pxIf.PxValid = 1'b1;
        pxIf.PxSof   = 1'b0;
        pxIf.PxData  = {8'hC0, 8'd4, 8'h5A};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_rdy", pxIf.PxReady, 1'b0);
            checkOutput("stall_wr", {WrEn1, WrEn0}, 2'b00);
        end
        @(posedge clk);
        #1;
        WE0 = 1'b1;
        applyStimulus(1'b0, 20'd4, {8'hC0, 8'd4, 8'h5A}, 1'b0);
        for (int i = 5; i < 8; i++) begin
            pxIf.PxValid = 1'b0;
            @(negedge clk);
            checkOutput("idle_nowr", {WrEn1, WrEn0}, 2'b00);
            @(posedge clk);
            #1;
            applyStimulus(1'b0, 20'(i), {8'hC0, 8'(i), 8'h5A}, 1'b0);
        end
        checkFrameDone(1'b0, "c");
        checkOutput("syncerr_clean", SyncErr, 1'b0);

        // Frame D into buffer 1 with a stray SOF on pixel 5.
        WE0 = 1'b0;
        WE1 = 1'b1;
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 20'(i), {8'hD0, 8'(i), 8'h5A}, i == 0);
        applyStimulus(1'b1, SOF_EN ? 20'd0 : 20'd5, {8'hD0, 8'd5, 8'h5A}, 1'b1);
        pxIf.PxValid = 1'b0;
        @(negedge clk);
        checkOutput("sof_err", SyncErr, SOF_EN);
        @(posedge clk);
        #1;
        begin
            int remain;
            int startAddr;
            remain    = SOF_EN ? 7 : 2;
            startAddr = SOF_EN ? 1 : 6;
            for (int i = 0; i < remain; i++)
                applyStimulus(1'b1, 20'(startAddr + i),
                              {8'hD1, 8'(i), 8'h5A}, 1'b0);
        end
        checkFrameDone(1'b1, "d");

        // Frame E into buffer 0 with new geometry 3x1.
        AIPIn = 10'd3;
        AILIn = 10'd1;
        WE1   = 1'b0;
        WE0   = 1'b1;
        runFrame(1'b0, 3, 8'hE0);
        checkFrameDone(1'b0, "e");

        // Frame F into buffer 1 (2x4), reset after pixel 3.
        AIPIn = 10'd2;
        AILIn = 10'd4;
        WE0   = 1'b0;
        WE1   = 1'b1;
        runFrame(1'b1, 4, 8'hF0);
        pxIf.PxValid = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_outs", outVec, 52'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        WE0   = 1'b1;

        // Both grants high after reset: buffer 0 restarts from address 0.
        runFrame(1'b0, 4, 8'h90);
        pxIf.PxValid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_reset_partial", Buf0Full, 1'b0);
        checkOutput("sb_empty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
# frame_loader

Write-side counterpart of the display controller. Accepts a 24-bit RGB pixel stream over a valid/ready handshake and writes complete frames alternately into ping-pong buffers 0 and 1. Write permission comes from the controller's `WE0`/`WE1` grants. The loader reports buffer-full status and raises `CSDisplay` once the first frame is resident, which starts display.

## Interface

Parameters:
- `ADDR_W`, default 20: buffer write address width (one address per pixel).
- `DATA_W`, default 24: pixel width, `{R[23:16], G[15:8], B[7:0]}`.

Ports:
- `clk`, input, 1: sole clock.
- `reset`, input, 1: synchronous, active-high.
- `AIPIn`, input, 10: active pixels per line.
- `AILIn`, input, 10: active lines per frame.
- `PxValid`, input, 1: source has a pixel.
- `PxSof`, input, 1: pixel is first of a frame.
- `PxData`, input, DATA_W: pixel.
- `PxReady`, output, 1: loader accepts the pixel this cycle.
- `WE0`, input, 1: controller grants writes to buffer 0.
- `WE1`, input, 1: controller grants writes to buffer 1.
- `WrEn0`, output, 1: buffer-0 write strobe.
- `WrEn1`, output, 1: buffer-1 write strobe.
- `WrAddr`, output, ADDR_W: write address.
- `WrData`, output, DATA_W: write data.
- `Buf0Full`, output, 1: buffer 0 holds a complete frame.
- `Buf1Full`, output, 1: buffer 1 holds a complete frame.
- `FrameDone`, output, 1: one-cycle pulse, frame completed.
- `CSDisplay`, output, 1: first frame loaded; display may start.
- `SyncErr`, output, 1: sticky SOF misalignment flag.

## Operation

- FSM states: `IDLE`, `FILL0`, `FULL0`, `FILL1`, `FULL1`.
- `IDLE`: go to `FILL0` when `WE0`=1. `WE0` has priority if both grants are high.
- `FILLb`:
  - `PxReady = WEb`.
  - An accept is `PxValid & PxReady`; it writes `WrEnb=1`, `WrAddr=addr`, `WrData=PxData`.
  - Each accept advances `px`; at `px==AIP-1`, `px` goes to 0 and `line` increments. `addr` increments every accept.
  - If `WEb` drops mid-fill, the fill stalls and all counters hold.
- Frame end: accept at `px==AIP-1 && line==AIL-1`.
  - Next cycle: `BufbFull=1`, `FrameDone=1` for one cycle, `px`, `line` and `addr` cleared, state goes to `FULLb`.
  - `CSDisplay` sets on the first completion of buffer 0 and holds until reset.
- `FULLb`: `PxReady=0`. Go to `FILL(1-b)` when `WE(1-b)`=1.
- Entering `FILLb` clears `BufbFull` and latches `AIPIn`/`AILIn` into `AIP`/`AIL`.
- Count arithmetic: 10-bit compares against `AIP-1` and `AIL-1` wrap, so a value of 0 means 1024.
- `addr` wraps modulo 2^ADDR_W; it never saturates.
- `WrEn0` and `WrEn1` are never both high.

## Timing

- Reset: state `IDLE`, counters 0. Every output is 0: `PxReady`, `WrEn0`, `WrEn1`, `WrAddr`, `WrData`, `Buf0Full`, `Buf1Full`, `FrameDone`, `CSDisplay`, `SyncErr`.
- `PxReady`, `WrEnb`, `WrAddr` and `WrData` are combinational from registered state, grants and input. Write latency is 0, in the accept cycle.
- `Buf*Full`, `FrameDone` and `CSDisplay` are registered: they change 1 cycle after the final accept.
- Minimum turnaround: 1 cycle spent in `FULLb` before the first accept into the other buffer.
- A reset mid-fill abandons the partial frame; the next frame writes from address 0 into buffer 0.

## Configuration

Macro: `FRAME_LOADER_SOF_CHECK_EN`.

- Defined:
  - An accept with `PxSof=1` at a nonzero position (`px`, `line`) sets `SyncErr`.
  - That pixel is then written at address 0, and the counters continue from position 1.
  - An accept with `PxSof=0` at position 0 also sets `SyncErr`; the pixel is written normally.
- Undefined: `PxSof` is ignored and `SyncErr` is tied to 0.

## Structure

- Shared package `display_pkg`:
  - FSM state enum `loader_state_t`.
  - `DATA_W`/`ADDR_W` defaults.
  - RGB field slice constants.
- Sub-module `frame_pos_counter`:
  - Holds `px`, `line` and `addr`.
  - Inputs: inc, clr, realign.
  - Outputs: `last_px`, `last_line`.

## Test plan

- Reset, `WE0=1`, `AIP=4`, `AIL=2`, 8 back-to-back pixels:
  - `WrEn0` strobes addr 0..7.
  - `Buf0Full`, `FrameDone` and `CSDisplay` rise 1 cycle after pixel 7.
- Continue with `WE1=1` and 8 more pixels:
  - `WrEn1` strobes addr 0..7; `Buf1Full`=1.
  - Raising `WE0` again clears `Buf0Full`.
- Drop `WE0` after pixel 3 for 5 cycles:
  - `PxReady`=0 throughout, no writes.
  - Resume at addr 4, with no pixel lost or duplicated.
- `PxValid` toggling 1/0 every cycle: writes only on valid cycles; addresses stay contiguous.
- With `FRAME_LOADER_SOF_CHECK_EN`, `PxSof` on pixel 5 of a frame: `SyncErr`=1 next cycle, and that pixel is written at addr 0.
- Assert reset after pixel 3 of buffer 1: all outputs 0; the next fill targets buffer 0 from addr 0.
